// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and round-robin helper for the BCD display scheduler.
package bcd_pkg;

  localparam int BIN_W      = 28;
  localparam int NUM_DIGITS = 8;
  localparam int NUM_REQ    = 4;

  localparam logic [3:0]       BLANK_DIGIT = 4'hF;
  localparam logic [BIN_W-1:0] BLANK_VALUE = {BIN_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nearest requester after 'last' going upward, wrapping; 'last' itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bcd_display_sched.sv
// Four-requester round-robin scheduler feeding a shared serial binary-to-BCD converter
// whose result is latched onto eight held display digits.
//
// state | meaning
// IDLE  | waiting for any req; grants, captures value and pulses ack on the next cycle
// CONV  | one double-dabble shift per clock, BIN_W clocks total
// DONE  | load digits and src, pulse done, return to IDLE
module bcd_display_sched #(
  parameter int BIN_W      = bcd_pkg::BIN_W,
  parameter int NUM_DIGITS = bcd_pkg::NUM_DIGITS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [BIN_W-1:0] val0,
  input  logic [BIN_W-1:0] val1,
  input  logic [BIN_W-1:0] val2,
  input  logic [BIN_W-1:0] val3,
  output logic [3:0]       ack,
  output logic             busy,
  output logic             done,
  output logic [1:0]       src,
  output logic [3:0]       HBin7,
  output logic [3:0]       HBin6,
  output logic [3:0]       HBin5,
  output logic [3:0]       HBin4,
  output logic [3:0]       HBin3,
  output logic [3:0]       HBin2,
  output logic [3:0]       HBin1,
  output logic [3:0]       HBin0
);

  import bcd_pkg::*;

  // One extra digit above the display absorbs the ninth decimal place, which is dropped.
  localparam int BCD_N = NUM_DIGITS + 1;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(BIN_W);

  state_t                  state;
  logic [BIN_W-1:0]        bin_sr;
  logic [BCD_W-1:0]        bcd_sr;
  logic [BCD_W-1:0]        bcd_adj;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              last_grant;
  logic [1:0]              cur_src;
  logic                    blank_val;
  logic [4*NUM_DIGITS-1:0] disp;

  logic [1:0]       pick;
  logic [BIN_W-1:0] val_sel;
  logic             unused_adj_msb;

  always_comb begin
    pick = rr_pick(req, last_grant);
    case (pick)
      2'd0:    val_sel = val0;
      2'd1:    val_sel = val1;
      2'd2:    val_sel = val2;
      default: val_sel = val3;
    endcase
  end

  for (genvar d = 0; d < BCD_N; d++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_sr[4*d +: 4]),
      .dout (bcd_adj[4*d +: 4])
    );
  end

  // The corrected top bit falls off the left end of the shift.
  assign unused_adj_msb = bcd_adj[BCD_W-1];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      ack        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      src        <= '0;
      disp       <= {NUM_DIGITS{BLANK_DIGIT}};
      last_grant <= 2'd3;
      cur_src    <= '0;
      blank_val  <= 1'b0;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      cnt        <= '0;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= CONV;
            busy       <= 1'b1;
            ack        <= 4'b0001 << pick;
            last_grant <= pick;
            cur_src    <= pick;
            bin_sr     <= val_sel;
            bcd_sr     <= '0;
            cnt        <= CNT_W'(BIN_W - 1);
            blank_val  <= (val_sel == {BIN_W{1'b1}});
          end
        end
        CONV: begin
          bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
          bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          src   <= cur_src;
          disp  <= blank_val ? {NUM_DIGITS{BLANK_DIGIT}} : bcd_sr[4*NUM_DIGITS-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HBin0 = disp[3:0];
  assign HBin1 = disp[7:4];
  assign HBin2 = disp[11:8];
  assign HBin3 = disp[15:12];
  assign HBin4 = disp[19:16];
  assign HBin5 = disp[23:20];
  assign HBin6 = disp[27:24];
  assign HBin7 = disp[31:28];

endmodule

// File: tb/tb_bcd_display_sched.sv
// Randomized scoreboard bench: expected grants/results are queued from a decimal reference
// model at issue time and compared by an independent monitor when ack/done appear.
module tb_bcd_display_sched;

  localparam int W       = 28;
  localparam int LATENCY = 29;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req     = 4'b0000;
  logic [W-1:0] vals [4];
  logic [3:0]   ack;
  logic         busy;
  logic         done;
  logic [1:0]   src;
  logic [3:0]   h7, h6, h5, h4, h3, h2, h1, h0;
  logic [31:0]  digits;

  always #5 clock = ~clock;

  bcd_display_sched dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .val0    (vals[0]),
    .val1    (vals[1]),
    .val2    (vals[2]),
    .val3    (vals[3]),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .src     (src),
    .HBin7   (h7),
    .HBin6   (h6),
    .HBin5   (h5),
    .HBin4   (h4),
    .HBin3   (h3),
    .HBin2   (h2),
    .HBin1   (h1),
    .HBin0   (h0)
  );

  assign digits = {h7, h6, h5, h4, h3, h2, h1, h0};

  typedef struct {
    int          src;
    logic [31:0] dig;
  } res_t;

  int   checks     = 0;
  int   errors     = 0;
  int   model_last = 3;
  int   exp_grant[$];
  res_t exp_res[$];

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Decimal reference: all-ones input blanks, otherwise the low eight decimal digits.
  function automatic logic [31:0] model_digits(input logic [W-1:0] v);
    longint      x;
    logic [31:0] r;
    if (v == {W{1'b1}}) return 32'hFFFF_FFFF;
    x = longint'(v) % 100000000;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return {W{1'b1}};
      1:       return W'($urandom_range(100000000, 268435455));
      2:       return W'($urandom_range(0, 999));
      default: return W'($urandom);
    endcase
  endfunction

  // Queue the next n grants a held request mask should receive, in round-robin order.
  task automatic push_exp(input logic [3:0] mask, input int n);
    int   g;
    res_t r;
    g = model_last;
    for (int k = 0; k < n; k++) begin
      do g = (g + 1) % 4; while (!mask[g]);
      exp_grant.push_back(g);
      r.src = g;
      r.dig = model_digits(vals[g]);
      exp_res.push_back(r);
    end
    model_last = g;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic monitor_loop();
    logic        rst_prev;
    logic        in_flight;
    logic [31:0] held;
    int          held_src;
    int          cyc;
    int          ack_cyc;
    int          idx;
    int          g;
    logic        exp_busy;
    res_t        r;
    rst_prev  = 1'b1;
    in_flight = 1'b0;
    held      = 32'hFFFF_FFFF;
    held_src  = 0;
    cyc       = 0;
    ack_cyc   = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!rst_prev) begin
        chk("reset_ack", ack, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_src", src, 0);
        chk("reset_digits", digits, 32'hFFFF_FFFF);
        held      = 32'hFFFF_FFFF;
        held_src  = 0;
        in_flight = 1'b0;
      end else begin
        exp_busy = in_flight;
        if (ack != 4'b0000) begin
          chk("ack_onehot", $onehot(ack), 1);
          idx = 0;
          for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
          if (exp_grant.size() == 0) begin
            chk("unexpected_grant", idx, -1);
          end else begin
            g = exp_grant.pop_front();
            chk("grant_index", idx, g);
          end
          ack_cyc   = cyc;
          in_flight = 1'b1;
          exp_busy  = 1'b1;
        end
        if (done) begin
          exp_busy = 1'b0;
          if (exp_res.size() == 0) begin
            chk("unexpected_done", digits, -1);
          end else begin
            r = exp_res.pop_front();
            chk("result_digits", digits, r.dig);
            chk("result_src", src, r.src);
            chk("grant_to_done_latency", cyc - ack_cyc, LATENCY);
            held     = r.dig;
            held_src = r.src;
          end
          in_flight = 1'b0;
        end else begin
          chk("digits_hold", digits, held);
          chk("src_hold", src, held_src);
        end
        chk("busy", busy, exp_busy);
      end
      rst_prev = reset_n;
    end
  endtask

  // Hold 'mask' until n conversions have completed, then drop it before another grant.
  task automatic run(input logic [3:0] mask, input int n);
    int d;
    int t;
    int first;
    push_exp(mask, n);
    d     = 0;
    t     = 0;
    first = -1;
    req   = mask;
    while (d < n && t < 40 * n) begin
      step();
      t++;
      if (ack != 4'b0000 && first < 0) first = t;
      if (done) d++;
    end
    req = 4'b0000;
    chk("first_ack_latency", first, 1);
    chk("done_count", d, n);
  endtask

  task automatic wait_ack(output int t);
    t = 0;
    do begin
      step();
      t++;
    end while (ack == 4'b0000 && t < 10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int       t;
    int       d;
    logic [3:0] m;
    logic [W-1:0] v;

    for (int i = 0; i < 4; i++) vals[i] = '0;
    fork
      monitor_loop();
    join_none

    repeat (3) step();
    reset_n    = 1'b1;
    model_last = 3;

    // Directed cases, the first granted on the very first edge out of reset.
    vals[0] = W'(12345678);
    run(4'b0001, 1);
    chk("dir_12345678", model_digits(vals[0]), 32'h1234_5678);
    vals[1] = {W{1'b1}};
    run(4'b0010, 1);
    vals[2] = W'(268435454);
    run(4'b0100, 1);
    vals[3] = '0;
    run(4'b1000, 1);
    vals[2] = W'(100000000);
    run(4'b0100, 1);
    vals[1] = W'(99999999);
    run(4'b0010, 1);

    // All four requesting: five grants walk the ring once and wrap.
    for (int i = 0; i < 4; i++) vals[i] = W'(1111111 * (i + 1) + 7);
    model_last = 3;
    vals[3] = '0;
    run(4'b1000, 1);
    vals[3] = W'(4444451);
    run(4'b1111, 5);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) vals[i] = rand_val();
      m = 4'($urandom_range(1, 15));
      run(m, $urandom_range(1, 3));
    end

    // Value and request change mid-conversion must not affect the captured result.
    vals[0] = rand_val();
    push_exp(4'b0001, 1);
    req = 4'b0001;
    wait_ack(t);
    chk("midconv_ack_latency", t, 1);
    repeat (5) step();
    vals[0] = ~vals[0];
    req     = 4'b0000;
    d = 0;
    for (int k = 0; k < 40 && d == 0; k++) begin
      step();
      if (done) d = 1;
    end
    chk("midconv_done_seen", d, 1);

    // Reset landing on the tenth conversion edge abandons the result.
    vals[0] = rand_val();
    push_exp(4'b0001, 1);
    void'(exp_res.pop_back());
    req = 4'b0001;
    wait_ack(t);
    chk("abort_ack_latency", t, 1);
    req = 4'b0000;
    repeat (9) step();
    reset_n = 1'b0;
    step();
    reset_n    = 1'b1;
    model_last = 3;
    repeat (40) step();

    // After reset requester 0 has priority over 3.
    vals[0] = rand_val();
    vals[3] = rand_val();
    run(4'b1001, 2);

    repeat (5) step();
    chk("grant_queue_drained", exp_grant.size(), 0);
    chk("result_queue_drained", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
